// File: rtl/wb_cpu_master_pkg.sv
// Shared definitions for the CPU-to-Wishbone initiator: FSM encodings,
// default watchdog limit and the watchdog counter sizing helper.
package wb_cpu_master_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LO   = 3'd1,
    ST_GAP  = 3'd2,
    ST_HI   = 3'd3,
    ST_RESP = 3'd4
  } state_t;

  localparam int TIMEOUT_DEFAULT = 255;

  // Read data returned to the CPU when a read cycle is abandoned.
  localparam logic [15:0] RD_ERR_DATA = 16'hFFFF;

  // The counter only has to reach TIMEOUT-1, so $clog2(TIMEOUT) bits suffice.
  function automatic int wd_width(input int timeout);
    return (timeout < 2) ? 1 : $clog2(timeout);
  endfunction

endpackage

// File: rtl/wb_cpu_master_watchdog.sv
// Bus watchdog: counts unacknowledged strobe cycles and flags the cycle in
// which the TIMEOUT-th strobe is being presented.
module wb_watchdog
  import wb_cpu_master_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int W = wd_width(TIMEOUT);
  localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

  logic [W-1:0] cnt_r;

  // Wait-state counter; saturates at the last allowed strobe cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_r <= '0;
    end else if (clr) begin
      cnt_r <= '0;
    end else if (en && (cnt_r != LAST)) begin
      cnt_r <= cnt_r + W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign expired = (cnt_r == LAST);

endmodule

// File: rtl/wb_cpu_master.sv
// Wishbone initiator carrying single CPU requests onto the 20-bit bus;
// unaligned words become two byte cycles, silent slaves are timed out.
module wb_cpu_master
  import wb_cpu_master_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [19:0] cpu_adr_i,
  input  logic [15:0] cpu_dat_i,
  input  logic        cpu_we_i,
  input  logic        cpu_byte_i,
  input  logic        cpu_req_i,
  output logic [15:0] cpu_dat_o,
  output logic        cpu_ack_o,
  output logic        cpu_err_o,
  output logic [19:0] wb_adr_o,
  output logic [15:0] wb_dat_o,
  input  logic [15:0] wb_dat_i,
  output logic        wb_we_o,
  output logic        wb_byte_o,
  output logic        wb_stb_o,
  output logic        wb_cyc_o,
  input  logic        wb_ack_i
);

  state_t      state_r, state_s;
  logic [19:0] adr_r;
  logic [15:0] dat_r;
  logic        we_r;
  logic        byte_r;
  logic        split_r;
  logic [7:0]  rd_lo_r, rd_lo_s;
  logic        lat_en_s;
  logic        req_split_s;

  logic [19:0] wb_adr_s;
  logic [15:0] wb_dat_s;
  logic        wb_we_s, wb_byte_s, wb_stb_s, wb_cyc_s;
  logic [15:0] cpu_dat_s;
  logic        cpu_ack_s, cpu_err_s;

  logic        wd_clr_s, wd_en_s, wd_expired_s;

  assign req_split_s = ~cpu_byte_i & cpu_adr_i[0];

  // The watchdog only runs while a strobe is being presented.
  assign wd_clr_s = (state_r != ST_LO) && (state_r != ST_HI);
  assign wd_en_s  = ~wd_clr_s & ~wb_ack_i;

  wb_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr     (wd_clr_s),
    .en      (wd_en_s),
    .expired (wd_expired_s)
  );

  // Next-state and next-output decode; every output is the registered
  // image of the values chosen here for the state being entered.
  always_comb begin
    state_s   = state_r;
    lat_en_s  = 1'b0;
    rd_lo_s   = rd_lo_r;
    wb_adr_s  = wb_adr_o;
    wb_dat_s  = wb_dat_o;
    wb_we_s   = wb_we_o;
    wb_byte_s = wb_byte_o;
    wb_stb_s  = 1'b0;
    wb_cyc_s  = 1'b0;
    cpu_dat_s = cpu_dat_o;
    cpu_ack_s = 1'b0;
    cpu_err_s = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (cpu_req_i) begin
          state_s  = ST_LO;
          lat_en_s = 1'b1;
          wb_stb_s = 1'b1;
          wb_cyc_s = 1'b1;
          wb_adr_s = cpu_adr_i;
          wb_we_s  = cpu_we_i;
          if (req_split_s || cpu_byte_i) begin
            wb_byte_s = 1'b1;
            wb_dat_s  = {8'h00, cpu_dat_i[7:0]};
          end else begin
            wb_byte_s = 1'b0;
            wb_dat_s  = cpu_dat_i;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_LO: begin
        if (wb_ack_i) begin
          if (split_r) begin
            state_s  = ST_GAP;
            wb_cyc_s = 1'b1;
            rd_lo_s  = wb_dat_i[7:0];
          end else begin
            state_s   = ST_RESP;
            cpu_ack_s = 1'b1;
            if (!we_r) begin
              cpu_dat_s = byte_r ? {8'h00, wb_dat_i[7:0]} : wb_dat_i;
            end else begin
              cpu_dat_s = cpu_dat_o;
            end
          end
        end else if (wd_expired_s) begin
          // Abandon the access; any pending high half is never issued.
          state_s   = ST_RESP;
          cpu_ack_s = 1'b1;
          cpu_err_s = 1'b1;
          if (!we_r) begin
            cpu_dat_s = RD_ERR_DATA;
          end else begin
            cpu_dat_s = cpu_dat_o;
          end
        end else begin
          wb_stb_s = 1'b1;
          wb_cyc_s = 1'b1;
        end
      end

      ST_GAP: begin
        state_s   = ST_HI;
        wb_stb_s  = 1'b1;
        wb_cyc_s  = 1'b1;
        wb_adr_s  = adr_r + 20'd1;
        wb_byte_s = 1'b1;
        wb_dat_s  = {8'h00, dat_r[15:8]};
      end

      ST_HI: begin
        if (wb_ack_i) begin
          state_s   = ST_RESP;
          cpu_ack_s = 1'b1;
          if (!we_r) begin
            cpu_dat_s = {wb_dat_i[7:0], rd_lo_r};
          end else begin
            cpu_dat_s = cpu_dat_o;
          end
        end else if (wd_expired_s) begin
          state_s   = ST_RESP;
          cpu_ack_s = 1'b1;
          cpu_err_s = 1'b1;
          if (!we_r) begin
            cpu_dat_s = RD_ERR_DATA;
          end else begin
            cpu_dat_s = cpu_dat_o;
          end
        end else begin
          wb_stb_s = 1'b1;
          wb_cyc_s = 1'b1;
        end
      end

      ST_RESP: begin
        state_s = ST_IDLE;
      end

      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, request latch and registered outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r   <= ST_IDLE;
      adr_r     <= 20'h00000;
      dat_r     <= 16'h0000;
      we_r      <= 1'b0;
      byte_r    <= 1'b0;
      split_r   <= 1'b0;
      rd_lo_r   <= 8'h00;
      wb_adr_o  <= 20'h00000;
      wb_dat_o  <= 16'h0000;
      wb_we_o   <= 1'b0;
      wb_byte_o <= 1'b0;
      wb_stb_o  <= 1'b0;
      wb_cyc_o  <= 1'b0;
      cpu_dat_o <= 16'h0000;
      cpu_ack_o <= 1'b0;
      cpu_err_o <= 1'b0;
    end else begin
      state_r   <= state_s;
      rd_lo_r   <= rd_lo_s;
      wb_adr_o  <= wb_adr_s;
      wb_dat_o  <= wb_dat_s;
      wb_we_o   <= wb_we_s;
      wb_byte_o <= wb_byte_s;
      wb_stb_o  <= wb_stb_s;
      wb_cyc_o  <= wb_cyc_s;
      cpu_dat_o <= cpu_dat_s;
      cpu_ack_o <= cpu_ack_s;
      cpu_err_o <= cpu_err_s;
      if (lat_en_s) begin
        adr_r   <= cpu_adr_i;
        dat_r   <= cpu_dat_i;
        we_r    <= cpu_we_i;
        byte_r  <= cpu_byte_i;
        split_r <= req_split_s;
      end else begin
        adr_r   <= adr_r;
        dat_r   <= dat_r;
        we_r    <= we_r;
        byte_r  <= byte_r;
        split_r <= split_r;
      end
    end
  end

endmodule

// File: tb/tb_wb_cpu_master.sv
// Bench for wb_cpu_master: table of CPU requests against a wait-state
// programmable slave, with scoreboarded bus cycles and CPU responses.
module tb_wb_cpu_master;

  localparam int TO = 8;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [19:0] cpu_adr_i = 20'h0;
  logic [15:0] cpu_dat_i = 16'h0;
  logic        cpu_we_i = 1'b0;
  logic        cpu_byte_i = 1'b0;
  logic        cpu_req_i = 1'b0;
  logic [15:0] cpu_dat_o;
  logic        cpu_ack_o, cpu_err_o;
  logic [19:0] wb_adr_o;
  logic [15:0] wb_dat_o;
  logic [15:0] wb_dat_i = 16'hDEAD;
  logic        wb_we_o, wb_byte_o, wb_stb_o, wb_cyc_o;
  logic        wb_ack_i = 1'b0;

  wb_cpu_master #(.TIMEOUT(TO)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cpu_adr_i(cpu_adr_i), .cpu_dat_i(cpu_dat_i), .cpu_we_i(cpu_we_i),
    .cpu_byte_i(cpu_byte_i), .cpu_req_i(cpu_req_i),
    .cpu_dat_o(cpu_dat_o), .cpu_ack_o(cpu_ack_o), .cpu_err_o(cpu_err_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
    .wb_we_o(wb_we_o), .wb_byte_o(wb_byte_o), .wb_stb_o(wb_stb_o),
    .wb_cyc_o(wb_cyc_o), .wb_ack_i(wb_ack_i)
  );

  always #20 clk_i = ~clk_i;

  typedef struct {
    logic [19:0] adr; logic [15:0] dat; logic we; logic byt;
    int wl; int wh; logic [15:0] sdl; logic [15:0] sdh; logic noack; logic busy;
    logic [15:0] exp_dat; logic exp_err; int exp_lat; int exp_stb; int exp_gap;
  } vec_t;

  typedef struct { logic [19:0] adr; logic [15:0] dat; logic we; logic byt; } wbc_t;
  typedef struct { logic [15:0] dat; logic err; int lat; } rsp_t;

  wbc_t wb_q[$];
  rsp_t rsp_q[$];
  vec_t vecs[12];

  int n_vec = 0;
  int n_miss = 0;

  int s_wl, s_wh, s_phase, s_wcnt, s_stb_cnt, s_gap_cnt;
  logic [15:0] s_dl, s_dh;
  logic s_noack = 1'b1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Bus cycles the request should produce: one cycle, or a byte pair at A and A+1.
  task automatic push_wb(input vec_t v);
    logic [19:0] a_hi;
    if (v.byt || !v.adr[0]) begin
      wb_q.push_back('{v.adr, v.byt ? {8'h00, v.dat[7:0]} : v.dat, v.we, v.byt});
    end else begin
      wb_q.push_back('{v.adr, {8'h00, v.dat[7:0]}, v.we, 1'b1});
      a_hi = v.adr + 20'd1;
      if (!v.noack) wb_q.push_back('{a_hi, {8'h00, v.dat[15:8]}, v.we, 1'b1});
    end
  endtask

  task automatic setup_slave(input vec_t v);
    s_wl = v.wl; s_wh = v.wh; s_dl = v.sdl; s_dh = v.sdh; s_noack = v.noack;
    s_phase = 0; s_wcnt = 0; s_stb_cnt = 0; s_gap_cnt = 0;
  endtask

  // Slave model and bus-cycle monitor, acting away from the active edge.
  always @(negedge clk_i) begin
    wbc_t e;
    wb_ack_i = 1'b0;
    wb_dat_i = 16'hDEAD;
    if (wb_stb_o) begin
      if (s_wcnt == 0) begin
        if (wb_q.size() == 0) begin
          n_vec++; n_miss++;
          $display("FAIL wb_unexpected_cycle: got adr %h, expected no cycle", wb_adr_o);
        end else begin
          e = wb_q.pop_front();
          chk("wb_adr", 32'(wb_adr_o), 32'(e.adr));
          chk("wb_dat", 32'(wb_dat_o), 32'(e.dat));
          chk("wb_byte", 32'(wb_byte_o), 32'(e.byt));
          chk("wb_we", 32'(wb_we_o), 32'(e.we));
        end
      end
      s_stb_cnt++;
      if (!s_noack && s_wcnt == ((s_phase == 0) ? s_wl : s_wh)) begin
        wb_ack_i = 1'b1;
        wb_dat_i = (s_phase == 0) ? s_dl : s_dh;
      end
      s_wcnt++;
    end else begin
      if (wb_cyc_o) s_gap_cnt++;
      if (s_wcnt != 0) s_phase++;
      s_wcnt = 0;
    end
  end

  task automatic run_vec(input vec_t v, input int idx);
    int lat;
    rsp_t r;
    setup_slave(v);
    push_wb(v);
    rsp_q.push_back('{v.exp_dat, v.exp_err, v.exp_lat});
    @(negedge clk_i);
    cpu_adr_i = v.adr; cpu_dat_i = v.dat; cpu_we_i = v.we; cpu_byte_i = v.byt;
    cpu_req_i = 1'b1;
    @(negedge clk_i);
    cpu_req_i = 1'b0;
    cpu_adr_i = 20'h0; cpu_dat_i = 16'h0;
    lat = 1;
    while (!cpu_ack_o && lat < 64) begin
      // A request while busy must be dropped without a new bus cycle.
      if (v.busy && lat == 2) begin
        cpu_adr_i = 20'h55555; cpu_req_i = 1'b1;
      end else begin
        cpu_req_i = 1'b0;
      end
      @(negedge clk_i);
      lat++;
    end
    cpu_req_i = 1'b0;
    r = rsp_q.pop_front();
    if (!cpu_ack_o) begin
      n_vec++; n_miss++;
      $display("FAIL v%0d cpu_ack_timeout: got no ack, expected ack at cycle %0d", idx, r.lat);
    end else begin
      chk($sformatf("v%0d cpu_dat", idx), 32'(cpu_dat_o), 32'(r.dat));
      chk($sformatf("v%0d cpu_err", idx), 32'(cpu_err_o), 32'(r.err));
      chk($sformatf("v%0d ack_cycle", idx), 32'(lat), 32'(r.lat));
    end
    @(negedge clk_i);
    chk($sformatf("v%0d ack_pulse", idx), 32'(cpu_ack_o), 32'(0));
    chk($sformatf("v%0d stb_cycles", idx), 32'(s_stb_cnt), 32'(v.exp_stb));
    chk($sformatf("v%0d gap_cycles", idx), 32'(s_gap_cnt), 32'(v.exp_gap));
    chk($sformatf("v%0d wb_left", idx), 32'(wb_q.size()), 32'(0));
    wb_q.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t vr;
    //             adr        dat      we    byt  wl wh sdl       sdh       noack busy  exp_dat  err  lat stb gap
    vecs[0]  = '{20'h00400, 16'hBEEF, 1'b1, 1'b0, 0, 0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 2, 1, 0};
    vecs[1]  = '{20'hB8001, 16'h0000, 1'b0, 1'b1, 2, 0, 16'h77A5, 16'h0000, 1'b0, 1'b1, 16'h00A5, 1'b0, 4, 3, 0};
    vecs[2]  = '{20'h00101, 16'h0000, 1'b0, 1'b0, 0, 0, 16'hEE34, 16'h5512, 1'b0, 1'b0, 16'h1234, 1'b0, 4, 2, 1};
    vecs[3]  = '{20'hFFFFF, 16'hCAFE, 1'b1, 1'b0, 0, 0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h1234, 1'b0, 4, 2, 1};
    vecs[4]  = '{20'h20000, 16'h0000, 1'b0, 1'b0, 1, 0, 16'hA55A, 16'h0000, 1'b0, 1'b0, 16'hA55A, 1'b0, 3, 2, 0};
    vecs[5]  = '{20'h00007, 16'h9C3D, 1'b1, 1'b1, 0, 0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'hA55A, 1'b0, 2, 1, 0};
    vecs[6]  = '{20'h00200, 16'h0000, 1'b0, 1'b0, 0, 0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'hFFFF, 1'b1, 9, 8, 0};
    vecs[7]  = '{20'h00300, 16'h0000, 1'b0, 1'b0, 7, 0, 16'h1357, 16'h0000, 1'b0, 1'b0, 16'h1357, 1'b0, 9, 8, 0};
    vecs[8]  = '{20'h00401, 16'h0000, 1'b0, 1'b0, 0, 0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'hFFFF, 1'b1, 9, 8, 0};
    vecs[9]  = '{20'h00600, 16'h1111, 1'b1, 1'b0, 0, 0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'hFFFF, 1'b1, 9, 8, 0};
    vecs[10] = '{20'h00801, 16'h0000, 1'b0, 1'b0, 1, 2, 16'hAB78, 16'hCD56, 1'b0, 1'b0, 16'h5678, 1'b0, 7, 5, 1};
    vecs[11] = '{20'h00A00, 16'h0000, 1'b0, 1'b1, 0, 0, 16'h44C3, 16'h0000, 1'b0, 1'b0, 16'h00C3, 1'b0, 2, 1, 0};

    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("rst cpu_dat", 32'(cpu_dat_o), 32'(0));
    chk("rst cpu_ack", 32'(cpu_ack_o), 32'(0));
    chk("rst cpu_err", 32'(cpu_err_o), 32'(0));
    chk("rst wb_adr", 32'(wb_adr_o), 32'(0));
    chk("rst wb_dat", 32'(wb_dat_o), 32'(0));
    chk("rst wb_we", 32'(wb_we_o), 32'(0));
    chk("rst wb_byte", 32'(wb_byte_o), 32'(0));
    chk("rst wb_stb", 32'(wb_stb_o), 32'(0));
    chk("rst wb_cyc", 32'(wb_cyc_o), 32'(0));

    for (int i = 0; i < 12; i++) run_vec(vecs[i], i);

    // Reset during the GAP of a split read: the request is lost silently.
    vr = '{20'h00501, 16'h0000, 1'b0, 1'b0, 0, 0, 16'h0011, 16'h0022, 1'b0, 1'b0, 16'h0000, 1'b0, 0, 0, 0};
    setup_slave(vr);
    push_wb(vr);
    @(negedge clk_i);
    cpu_adr_i = vr.adr; cpu_we_i = 1'b0; cpu_byte_i = 1'b0; cpu_req_i = 1'b1;
    @(negedge clk_i);
    cpu_req_i = 1'b0;
    @(negedge clk_i);
    chk("gap stb", 32'(wb_stb_o), 32'(0));
    chk("gap cyc", 32'(wb_cyc_o), 32'(1));
    rst_i = 1'b1;
    #1;
    chk("rst_mid stb", 32'(wb_stb_o), 32'(0));
    chk("rst_mid cyc", 32'(wb_cyc_o), 32'(0));
    @(negedge clk_i);
    rst_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_i);
      chk("rst_mid no_ack", 32'(cpu_ack_o), 32'(0));
      chk("rst_mid no_stb", 32'(wb_stb_o), 32'(0));
    end
    wb_q.delete();

    vr = '{20'h00C00, 16'h0000, 1'b0, 1'b0, 0, 0, 16'h2468, 16'h0000, 1'b0, 1'b0, 16'h2468, 1'b0, 2, 1, 0};
    run_vec(vr, 12);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
